mvm3_stream_host: RTL
=====================

Name: mvm3_stream_host

Overview:
- Initiator/sink counterpart of the 3x3 matrix-vector accelerator stream interface.
- Holds one problem (9 matrix bytes, row-major, then 3 vector bytes) loaded through a simple write port.
- On start, streams the 12 bytes into the accelerator's s_valid/s_ready port, then collects the 3 results and their overflow flags from its m_valid/m_ready port.
- Used by block-level benches and the on-chip test harness to drive the accelerator back-to-back.

Parameters:
- M_DIM, 3, matrix/vector dimension; word count sent = M_DIM*M_DIM + M_DIM.
- IN_W, 8, signed input word width.
- OUT_W, 16, signed result width.
- TIMEOUT, 1000, maximum cycles from start to completion before abort.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- cfg_wr_en  input  1  write strobe for the problem buffer.
- cfg_addr  input  4  buffer index: 0..8 = matrix, 9..11 = vector.
- cfg_data  input  IN_W  byte to write.
- start  input  1  single-cycle request to run one problem.
- busy  output  1  high from accepted start until done/abort.
- done  output  1  sticky completion flag, cleared by next accepted start.
- err  output  1  sticky timeout flag, cleared by next accepted start.
- tx_valid  output  1  to accelerator s_valid.
- tx_ready  input  1  from accelerator s_ready.
- tx_data  output  IN_W  to accelerator data_in.
- rx_valid  input  1  from accelerator m_valid.
- rx_ready  output  1  to accelerator m_ready.
- rx_data  input  OUT_W  from accelerator data_out.
- rx_overflow  input  1  from accelerator overflow.
- res_addr  input  2  result readback index 0..M_DIM-1.
- res_data  output  OUT_W  result[res_addr], combinational read.
- res_ovf  output  1  overflow[res_addr], combinational read.
- ovf_count  output  2  number of results of the last run with overflow set.

Behaviour:
- Reset (reset=0, async): state IDLE; busy, done, err, tx_valid, rx_ready = 0; tx_data = 0; ovf_count = 0; result and overflow buffers cleared to 0. The problem buffer is not reset.
- FSM states: IDLE, SEND, RECV, FIN.
- IDLE:
  - cfg_wr_en writes buffer[cfg_addr].
  - cfg_addr > 11 is ignored.
  - start -> SEND next cycle; clears done, err, ovf_count; zeroes word index, result index and watchdog.
- SEND:
  - tx_valid and tx_data are registered; tx_data = buffer[word index]. tx_valid rises the cycle after entering SEND.
  - A beat transfers on the edge where tx_valid & tx_ready.
  - While tx_valid=1 and tx_ready=0, tx_data is held stable.
  - After the beat with index 11 transfers, tx_valid drops the next cycle -> RECV.
- RECV:
  - rx_ready = 1.
  - Each edge with rx_valid & rx_ready stores rx_data and rx_overflow at the result index, increments it, and increments ovf_count if rx_overflow=1.
  - After beat M_DIM-1 -> FIN; rx_ready drops the same cycle.
- FIN: busy = 0, done = 1 (held); return to IDLE next cycle.
- Gating of writes and start:
  - cfg_wr_en and start are ignored whenever busy=1.
  - rx_ready is 0 outside RECV, so stray rx beats are never accepted.
- Watchdog:
  - Counts while busy. On reaching TIMEOUT-1 without completion: tx_valid=0, rx_ready=0, err=1, done=0 -> IDLE.
  - Partial results keep the values captured so far.
- busy = (state != IDLE && state != FIN).
- start coincident with cfg_wr_en in IDLE: the write takes effect and is included in the run.
- Reset mid-transfer aborts immediately; tx_valid deasserts asynchronously.
- Values are sign-preserving; no arithmetic is done on results.

Optional Feature:
- Macro MVM_HOST_THROTTLE_EN.
- When defined: an 8-bit LFSR (seed 8'hA5 at reset, advancing every cycle) gates both interfaces.
  - tx_valid may only newly rise when lfsr[0]=1; once raised it is held until the beat transfers.
  - rx_ready = (state==RECV) & lfsr[1].
  - Purpose: stress the accelerator's handshake.
- When undefined: no LFSR logic. tx_valid is continuous in SEND and rx_ready is continuous in RECV, as described above.

Test Plan:
- Accelerator responder model: load matrix {1,-8,3,9,-5,11,-7,8,-9} and vector {1,-22,3}, then start.
  - Required: 12 tx beats in buffer order.
  - Results 186, 152, -210 with overflow 0; ovf_count=0; done=1.
- Load matrix {10,11,12,127,127,127,1,2,3} and vector {127,127,127}, then run.
  - Required: results 4191, -17149, 762 with overflow 0,1,0; ovf_count=1.
- tx_ready held low 5 cycles mid-SEND.
  - Required: tx_data and tx_valid stable throughout; no duplicate or dropped beat.
- Responder never asserts rx_valid.
  - Required: err=1 and done=0 exactly TIMEOUT cycles after start; busy=0; tx_valid and rx_ready low.
- reset pulsed low during SEND beat 5.
  - Required: all outputs at reset values immediately.
  - A subsequent start resends from beat 0, using the unchanged problem buffer.
- Behaviour while busy:
  - Required: start and cfg_wr_en issued while busy have no effect; buffer contents unchanged on the following run.
  - Required: rx_valid pulsed while in IDLE is not accepted (rx_ready=0).

Source files
------------

// File: rtl/mvm3_stream_host.sv
// mvm3_stream_host: initiator/sink for the 3x3 matrix-vector accelerator stream port.
// Holds one problem (row-major matrix then vector), streams it out on start and
// collects the results and their overflow flags, with a watchdog abort.
// Optional build macro MVM_HOST_THROTTLE_EN adds LFSR-based handshake throttling.
module mvm3_stream_host #(
  parameter int unsigned M_DIM   = 3,
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_wr_en,
  input  logic [3:0]       cfg_addr,
  input  logic [IN_W-1:0]  cfg_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic [IN_W-1:0]  tx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [OUT_W-1:0] rx_data,
  input  logic             rx_overflow,
  input  logic [1:0]       res_addr,
  output logic [OUT_W-1:0] res_data,
  output logic             res_ovf,
  output logic [1:0]       ovf_count
);

  localparam int unsigned NumWords = M_DIM * M_DIM + M_DIM;
  localparam int unsigned WiW      = $clog2(NumWords);
  localparam int unsigned RiW      = $clog2(M_DIM + 1);
  localparam int unsigned WdW      = $clog2(TIMEOUT);

  localparam logic [3:0]     CfgLast  = 4'(NumWords - 1);
  localparam logic [WiW-1:0] WordLast = WiW'(NumWords - 1);
  localparam logic [RiW-1:0] ResLast  = RiW'(M_DIM - 1);
  localparam logic [WdW-1:0] WdLast   = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StSend, StRecv, StFin} state_e;

  state_e                          state_q, state_d;
  logic [WiW-1:0]                  word_idx_q, word_idx_d;
  logic [RiW-1:0]                  rx_idx_q, rx_idx_d;
  logic                            tx_valid_q, tx_valid_d;
  logic [IN_W-1:0]                 tx_data_q, tx_data_d;
  logic [1:0]                      ovf_cnt_q, ovf_cnt_d;
  logic                            done_q, done_d;
  logic                            err_q, err_d;
  logic [WdW-1:0]                  wdog_q, wdog_d;
  logic [NumWords-1:0][IN_W-1:0]   buf_q;
  logic [M_DIM-1:0][OUT_W-1:0]     res_q;
  logic [M_DIM-1:0]                ovf_q;
  logic                            cfg_we;
  logic                            rx_fire;
  logic                            tx_gate;
  logic                            rx_gate;

`ifdef MVM_HOST_THROTTLE_EN
  logic [7:0] lfsr_q;

  // Free-running maximal-length LFSR (x^8+x^6+x^5+x^4+1) used as a throttle pattern.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr_q <= 8'hA5;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign tx_gate = lfsr_q[0];
  assign rx_gate = lfsr_q[1];
`else
  assign tx_gate = 1'b1;
  assign rx_gate = 1'b1;
`endif

  assign busy      = (state_q == StSend) || (state_q == StRecv);
  assign done      = done_q;
  assign err       = err_q;
  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign rx_ready  = (state_q == StRecv) && rx_gate;
  assign rx_fire   = rx_valid && rx_ready;
  assign ovf_count = ovf_cnt_q;
  assign cfg_we    = (state_q == StIdle) && cfg_wr_en && (cfg_addr <= CfgLast);

  // Combinational result readback; indices past the last result read as zero.
  assign res_data = (32'(res_addr) < M_DIM) ? res_q[res_addr] : '0;
  assign res_ovf  = (32'(res_addr) < M_DIM) ? ovf_q[res_addr] : 1'b0;

  // Problem buffer: deliberately not reset so a problem survives a reset pulse.
  always_ff @(posedge clk) begin
    if (cfg_we) begin
      buf_q[cfg_addr] <= cfg_data;
    end
  end

  // Result and overflow capture, one slot per accepted rx beat.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= '0;
      ovf_q <= '0;
    end else if (rx_fire) begin
      res_q[rx_idx_q] <= rx_data;
      ovf_q[rx_idx_q] <= rx_overflow;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      word_idx_q <= '0;
      rx_idx_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      ovf_cnt_q  <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      rx_idx_q   <= rx_idx_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ovf_cnt_q  <= ovf_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      wdog_q     <= wdog_d;
    end
  end

  // Next-state logic: send phase, receive phase, then watchdog override.
  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    rx_idx_d   = rx_idx_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    ovf_cnt_d  = ovf_cnt_q;
    done_d     = done_q;
    err_d      = err_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StSend;
          done_d     = 1'b0;
          err_d      = 1'b0;
          ovf_cnt_d  = '0;
          word_idx_d = '0;
          rx_idx_d   = '0;
          wdog_d     = '0;
        end
      end
      StSend: begin
        wdog_d = wdog_q + WdW'(1);
        if (!tx_valid_q) begin
          if (tx_gate) begin
            tx_valid_d = 1'b1;
            tx_data_d  = buf_q[word_idx_q];
          end
        end else if (tx_ready) begin
          if (word_idx_q == WordLast) begin
            tx_valid_d = 1'b0;
            state_d    = StRecv;
          end else begin
            word_idx_d = word_idx_q + WiW'(1);
            tx_data_d  = buf_q[word_idx_d];
            // Unthrottled: valid stays up back-to-back; throttled: may pause here.
            tx_valid_d = tx_gate;
          end
        end
      end
      StRecv: begin
        wdog_d = wdog_q + WdW'(1);
        if (rx_fire) begin
          rx_idx_d = rx_idx_q + RiW'(1);
          if (rx_overflow) begin
            ovf_cnt_d = ovf_cnt_q + 2'd1;
          end
          if (rx_idx_q == ResLast) begin
            state_d = StFin;
            done_d  = 1'b1;
          end
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A completing beat on the same edge wins over the watchdog.
    if (busy && (wdog_q == WdLast) && (state_d != StFin)) begin
      state_d    = StIdle;
      tx_valid_d = 1'b0;
      err_d      = 1'b1;
      done_d     = 1'b0;
    end
  end

endmodule
